// File: rtl/txc_stream_arbiter_pkg.sv
// txc_pkg: shared state encoding, select-width helper and counter width for the TXC stream arbiter.
package txc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        ABORT = 2'd2
    } state_e;

    localparam int PKT_W = 16;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/txc_stream_arbiter_rr_select.sv
// txc_rr_select: rotating-priority pick of the first requester after the last grant.
module txc_rr_select #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   nxt,
    output logic               any
);

    logic [SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        nxt = last;
        idx = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = SEL_W'((int'(last) + i) % NUM_SRC);
            if (req[idx]) nxt = idx;
        end
    end

    assign any = |req;

endmodule

// File: rtl/txc_stream_arbiter.sv
// txc_stream_arbiter: packet-granular round-robin AXI4-Stream arbiter with a registered output stage.
// Optional mid-packet stall timeout and abort beat are enabled by defining TXC_ARB_TIMEOUT_EN.
module txc_stream_arbiter
    import txc_pkg::*;
#(
    parameter  int NUM_SRC        = 4,
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int SEL_W          = sel_w(NUM_SRC)
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [SEL_W-1:0]              m_axis_tdest,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [SEL_W-1:0]              grant_idx,
    output logic                          busy,
    output logic [PKT_W-1:0]              pkt_count,
    output logic                          timeout_err
);

    if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_err
        $error("txc_stream_arbiter: parameter out of range");
    end

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        grant_q, grant_d, rr_idx;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [SEL_W-1:0]        tdest_q, tdest_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;
    logic [PKT_W-1:0]        pkt_q, pkt_d;
    logic                    rr_any, out_free, src_valid, accept;
`ifdef TXC_ARB_TIMEOUT_EN
    logic                    tuser_q, tuser_d;
    logic                    timeout_q, timeout_d;
    logic [15:0]             stall_q, stall_d;
`endif

    txc_rr_select #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_rr_select (
        .req  (s_axis_tvalid),
        .last (grant_q),
        .nxt  (rr_idx),
        .any  (rr_any)
    );

    assign out_free  = ~tvalid_q | m_axis_tready;
    assign src_valid = s_axis_tvalid[grant_q];
    assign accept    = (state_q == LOCK) && src_valid && out_free;

    always_comb begin
        s_axis_tready          = '0;
        s_axis_tready[grant_q] = (state_q == LOCK) && out_free;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        tdata_d  = tdata_q;
        tdest_d  = tdest_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q & ~m_axis_tready;
        pkt_d    = pkt_q;
`ifdef TXC_ARB_TIMEOUT_EN
        tuser_d   = tuser_q;
        timeout_d = 1'b0;
        stall_d   = '0;
`endif
        if (accept) begin
            tdata_d  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            tlast_d  = s_axis_tlast[grant_q];
            tdest_d  = grant_q;
            tvalid_d = 1'b1;
`ifdef TXC_ARB_TIMEOUT_EN
            tuser_d  = 1'b0;
`endif
        end
        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    grant_d = rr_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (accept && s_axis_tlast[grant_q]) begin
                    pkt_d   = pkt_q + PKT_W'(1);
                    state_d = IDLE;
                end
`ifdef TXC_ARB_TIMEOUT_EN
                // Only cycles with the granted source idle count as a stall; backpressure does not.
                else if (!accept) begin
                    stall_d = stall_q + 16'(!src_valid);
                    if (stall_d == 16'(TIMEOUT_CYCLES)) begin
                        stall_d   = '0;
                        timeout_d = 1'b1;
                        state_d   = ABORT;
                    end
                end
`endif
            end
`ifdef TXC_ARB_TIMEOUT_EN
            ABORT: begin
                if (out_free) begin
                    tdata_d  = '0;
                    tlast_d  = 1'b1;
                    tuser_d  = 1'b1;
                    tdest_d  = grant_q;
                    tvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            grant_q   <= SEL_W'(NUM_SRC - 1);
            tdata_q   <= '0;
            tdest_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            pkt_q     <= '0;
`ifdef TXC_ARB_TIMEOUT_EN
            tuser_q   <= 1'b0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tdata_q   <= tdata_d;
            tdest_q   <= tdest_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
            pkt_q     <= pkt_d;
`ifdef TXC_ARB_TIMEOUT_EN
            tuser_q   <= tuser_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tdest  = tdest_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign grant_idx     = grant_q;
    assign busy          = (state_q != IDLE);
    assign pkt_count     = pkt_q;
`ifdef TXC_ARB_TIMEOUT_EN
    assign m_axis_tuser  = tuser_q;
    assign timeout_err   = timeout_q;
`else
    assign m_axis_tuser  = 1'b0;
    assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_txc_stream_arbiter.sv
// tb_txc_stream_arbiter: randomized self-checking bench with per-source packet queues as reference.
module tb_txc_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic [N*DW-1:0] s_axis_tdata = '0;
    logic [N-1:0]    s_axis_tvalid = '0;
    logic [N-1:0]    s_axis_tlast = '0;
    logic [N-1:0]    s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [1:0]      m_axis_tdest;
    logic            m_axis_tuser;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [1:0]      grant_idx;
    logic            busy;
    logic [15:0]     pkt_count;
    logic            timeout_err;

    txc_stream_arbiter #(
        .NUM_SRC        (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .pkt_count     (pkt_count),
        .timeout_err   (timeout_err)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int vprob = 100;
    int rmode = 0;
    int rdy_viol = 0;
    logic [N-1:0] taken = '0;
    logic [DW:0]  pend[N][$];
    logic [35:0]  out_q[$];
    int out_cyc[$];
    int acc_cyc[$];
    int to_cyc[$];

    function automatic logic [35:0] mk(input logic u, input logic [1:0] d, input logic l, input logic [31:0] x);
        return {u, d, l, x};
    endfunction

    task automatic clear_rec();
        out_q.delete();
        out_cyc.delete();
        acc_cyc.delete();
        to_cyc.delete();
        rdy_viol = 0;
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tlast = '0;
        s_axis_tdata = '0;
        m_axis_tready = 1'b0;
        taken = '0;
        for (int k = 0; k < N; k++) pend[k].delete();
        clear_rec();
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    // One cycle: sources present beats and hold them until accepted, sink applies its ready pattern.
    task automatic step();
        @(negedge ACLK);
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (taken[k]) begin
                pend[k].delete(0);
                s_axis_tvalid[k] = 1'b0;
            end
            if (!s_axis_tvalid[k] && pend[k].size() != 0 && $urandom_range(99) < vprob) begin
                s_axis_tvalid[k] = 1'b1;
                s_axis_tlast[k] = pend[k][0][DW];
                s_axis_tdata[k*DW +: DW] = pend[k][0][DW-1:0];
            end
        end
        m_axis_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(1)) : ((cyc % 3) == 0);
        #1;
        if ($countones(s_axis_tready) > 1 || (s_axis_tready != '0 && m_axis_tvalid && !m_axis_tready))
            rdy_viol++;
        if (timeout_err) to_cyc.push_back(cyc);
        if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back({m_axis_tuser, m_axis_tdest, m_axis_tlast, m_axis_tdata});
            out_cyc.push_back(cyc);
        end
        taken = s_axis_tvalid & s_axis_tready;
        if (taken != '0) acc_cyc.push_back(cyc);
    endtask

    task automatic run(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = !busy && !m_axis_tvalid;
            for (int k = 0; k < N; k++) if (pend[k].size() > int'(taken[k])) done = 1'b0;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL drain: got not idle after %0d cycles, want idle", budget);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        @(negedge ACLK);
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got v=%b l=%b u=%b want 000", m_axis_tvalid, m_axis_tlast, m_axis_tuser);
        end
        n_cmp++;
        if (m_axis_tdata !== '0 || m_axis_tdest !== 2'd0 || pkt_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_regs: got data=%h dest=%0d pkt=%0d want 0/0/0", m_axis_tdata, m_axis_tdest, pkt_count);
        end
        n_cmp++;
        if (grant_idx !== 2'd3 || busy !== 1'b0 || timeout_err !== 1'b0 || s_axis_tready !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got grant=%0d busy=%b to=%b rdy=%b want 3/0/0/0000",
                     grant_idx, busy, timeout_err, s_axis_tready);
        end
        do_reset();
    endtask

    task automatic test_single();
        int c0, p0;
        do_reset();
        vprob = 100;
        rmode = 0;
        p0 = int'(pkt_count);
        pend[0].push_back({1'b0, 32'h1});
        pend[0].push_back({1'b0, 32'h2});
        pend[0].push_back({1'b1, 32'h3});
        c0 = cyc;
        run(50);
        n_cmp++;
        if (out_q.size() != 3) begin
            n_bad++;
            $display("FAIL single_count: got %0d beats want 3", out_q.size());
        end
        for (int i = 0; i < 3 && i < out_q.size() && i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== mk(1'b0, 2'd0, i == 2, 32'(i + 1))) begin
                n_bad++;
                $display("FAIL single_beat%0d: got %h want %h", i, out_q[i], mk(1'b0, 2'd0, i == 2, 32'(i + 1)));
            end
            n_cmp++;
            if (out_cyc[i] != acc_cyc[i] + 1) begin
                n_bad++;
                $display("FAIL single_latency%0d: got %0d want %0d", i, out_cyc[i], acc_cyc[i] + 1);
            end
        end
        n_cmp++;
        if (acc_cyc.size() == 0 || acc_cyc[0] != c0 + 2) begin
            n_bad++;
            $display("FAIL single_arb: got first accept %0d want %0d", acc_cyc.size() ? acc_cyc[0] : -1, c0 + 2);
        end
        n_cmp++;
        if (pkt_count !== 16'(p0 + 1)) begin
            n_bad++;
            $display("FAIL single_pkt: got %0d want %0d", pkt_count, p0 + 1);
        end
    endtask

    task automatic test_round_robin();
        logic [35:0] ex[$];
        do_reset();
        vprob = 100;
        rmode = 0;
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < N; k++)
                for (int b = 0; b < 2; b++) begin
                    pend[k].push_back({b == 1, 32'(k * 256 + p * 16 + b)});
                    ex.push_back(mk(1'b0, 2'(k), b == 1, 32'(k * 256 + p * 16 + b)));
                end
        run(200);
        n_cmp++;
        if (out_q.size() != ex.size()) begin
            n_bad++;
            $display("FAIL rr_count: got %0d beats want %0d", out_q.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== ex[i]) begin
                n_bad++;
                $display("FAIL rr_beat%0d: got %h want %h", i, out_q[i], ex[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        vprob = 100;
        rmode = 2;
        for (int b = 0; b < 8; b++) pend[3].push_back({b == 7, 32'hB0 + 32'(b)});
        run(200);
        n_cmp++;
        if (out_q.size() != 8) begin
            n_bad++;
            $display("FAIL bp_count: got %0d beats want 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== mk(1'b0, 2'd3, i == 7, 32'hB0 + 32'(i))) begin
                n_bad++;
                $display("FAIL bp_beat%0d: got %h want %h", i, out_q[i], mk(1'b0, 2'd3, i == 7, 32'hB0 + 32'(i)));
            end
        end
        n_cmp++;
        if (rdy_viol != 0) begin
            n_bad++;
            $display("FAIL bp_ready: got %0d ready violations want 0", rdy_viol);
        end
    endtask

    task automatic test_random();
        logic [32:0] ex[N][$];
        int p0, cur, src, npk;
        logic [35:0] b;
        do_reset();
        vprob = 60;
        rmode = 1;
        p0 = int'(pkt_count);
        npk = 16;
        for (int p = 0; p < npk; p++) begin
            int k = $urandom_range(N - 1);
            int len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
                logic [32:0] bt = {j == len - 1, 32'($urandom)};
                pend[k].push_back(bt);
                ex[k].push_back(bt);
            end
        end
        run(4000);
        cur = -1;
        foreach (out_q[i]) begin
            b = out_q[i];
            src = int'(b[34:33]);
            n_cmp++;
            if (b[35] || (cur >= 0 && src != cur) || ex[src].size() == 0 || ex[src][0] !== b[32:0]) begin
                n_bad++;
                $display("FAIL rand_beat%0d: got %h want src %0d beat %h", i, b,
                         cur >= 0 ? cur : src, ex[src].size() ? ex[src][0] : 33'h0);
            end else begin
                ex[src].delete(0);
            end
            cur = b[32] ? -1 : src;
        end
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (ex[k].size() != 0) begin
                n_bad++;
                $display("FAIL rand_left%0d: got %0d beats undelivered want 0", k, ex[k].size());
            end
        end
        n_cmp++;
        if (pkt_count !== 16'(p0 + npk)) begin
            n_bad++;
            $display("FAIL rand_pkt: got %0d want %0d", pkt_count, p0 + npk);
        end
        n_cmp++;
        if (rdy_viol != 0) begin
            n_bad++;
            $display("FAIL rand_ready: got %0d ready violations want 0", rdy_viol);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        vprob = 100;
        rmode = 0;
        for (int b = 0; b < 4; b++) pend[2].push_back({b == 3, 32'h200 + 32'(b)});
        for (int i = 0; i < 20 && acc_cyc.size() < 2; i++) step();
        step();
        ARESETN = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_out: got v=%b data=%h l=%b want 0/0/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        n_cmp++;
        if (busy !== 1'b0 || grant_idx !== 2'd3 || s_axis_tready !== 4'b0 || pkt_count !== 16'd0) begin
            n_bad++;
            $display("FAIL rstmid_ctrl: got busy=%b grant=%0d rdy=%b pkt=%0d want 0/3/0000/0",
                     busy, grant_idx, s_axis_tready, pkt_count);
        end
        do_reset();
        vprob = 100;
        rmode = 0;
        pend[2].push_back({1'b1, 32'h2F});
        pend[0].push_back({1'b1, 32'h0F});
        run(50);
        n_cmp++;
        if (out_q.size() != 2 || out_q[0] !== mk(1'b0, 2'd0, 1'b1, 32'h0F) || out_q[1] !== mk(1'b0, 2'd2, 1'b1, 32'h2F)) begin
            n_bad++;
            $display("FAIL rstmid_order: got %0d beats first %h want src0 then src2",
                     out_q.size(), out_q.size() ? out_q[0] : 36'h0);
        end
    endtask

    task automatic test_timeout();
        int p0;
        do_reset();
        vprob = 100;
        rmode = 0;
        p0 = int'(pkt_count);
        pend[1].push_back({1'b0, 32'h11});
        pend[2].push_back({1'b1, 32'h22});
`ifdef TXC_ARB_TIMEOUT_EN
        run(300);
        n_cmp++;
        if (out_q.size() != 3) begin
            n_bad++;
            $display("FAIL to_count: got %0d beats want 3", out_q.size());
        end else begin
            n_cmp++;
            if (out_q[0] !== mk(1'b0, 2'd1, 1'b0, 32'h11)) begin
                n_bad++;
                $display("FAIL to_first: got %h want %h", out_q[0], mk(1'b0, 2'd1, 1'b0, 32'h11));
            end
            n_cmp++;
            if (out_q[1] !== mk(1'b1, 2'd1, 1'b1, 32'h0)) begin
                n_bad++;
                $display("FAIL to_abort: got %h want %h", out_q[1], mk(1'b1, 2'd1, 1'b1, 32'h0));
            end
            n_cmp++;
            if (out_q[2] !== mk(1'b0, 2'd2, 1'b1, 32'h22)) begin
                n_bad++;
                $display("FAIL to_next: got %h want %h", out_q[2], mk(1'b0, 2'd2, 1'b1, 32'h22));
            end
        end
        n_cmp++;
        if (to_cyc.size() != 1) begin
            n_bad++;
            $display("FAIL to_pulse: got %0d pulses want 1", to_cyc.size());
        end else if (acc_cyc.size() != 0) begin
            n_cmp++;
            if (to_cyc[0] - acc_cyc[0] < TO || to_cyc[0] - acc_cyc[0] > TO + 2) begin
                n_bad++;
                $display("FAIL to_delay: got %0d cycles want %0d..%0d", to_cyc[0] - acc_cyc[0], TO, TO + 2);
            end
        end
        n_cmp++;
        if (pkt_count !== 16'(p0 + 1)) begin
            n_bad++;
            $display("FAIL to_pkt: got %0d want %0d", pkt_count, p0 + 1);
        end
`else
        repeat (100) step();
        n_cmp++;
        if (grant_idx !== 2'd1 || busy !== 1'b1 || s_axis_tready[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_grant: got grant=%0d busy=%b rdy2=%b want 1/1/0", grant_idx, busy, s_axis_tready[2]);
        end
        n_cmp++;
        if (to_cyc.size() != 0 || timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_timeout: got %0d pulses want 0", to_cyc.size());
        end
        n_cmp++;
        if (out_q.size() != 1 || out_q[0] !== mk(1'b0, 2'd1, 1'b0, 32'h11)) begin
            n_bad++;
            $display("FAIL hold_out: got %0d beats first %h want 1 beat %h",
                     out_q.size(), out_q.size() ? out_q[0] : 36'h0, mk(1'b0, 2'd1, 1'b0, 32'h11));
        end
        n_cmp++;
        if (pkt_count !== 16'(p0)) begin
            n_bad++;
            $display("FAIL hold_pkt: got %0d want %0d", pkt_count, p0);
        end
        do_reset();
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
